// File: rtl/periph_responder.sv
// Memory-mapped timer/LED/7-seg/systick responder for a 32-byte window beside DataMemory.
// Reads are combinational (zero latency); writes land on the next rising clk edge.
// No backpressure: every access in the window completes in its own cycle.
module periph_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          DIGI_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Address,
    input  logic [31:0]       Write_data,
    output logic [31:0]       Read_data,
    output logic              hit,
    output logic              irq,
    output logic [LED_W-1:0]  leds,
    output logic [DIGI_W-1:0] digi
);

    localparam logic [2:0] SEL_TH   = 3'd0;
    localparam logic [2:0] SEL_TL   = 3'd1;
    localparam logic [2:0] SEL_TCON = 3'd2;
    localparam logic [2:0] SEL_LED  = 3'd3;
    localparam logic [2:0] SEL_DIGI = 3'd4;
    localparam logic [2:0] SEL_TICK = 3'd5;

    logic [31:0]       th_q,   th_d;
    logic [31:0]       tl_q,   tl_d;
    logic [2:0]        tcon_q, tcon_d;
    logic [LED_W-1:0]  led_q,  led_d;
    logic [DIGI_W-1:0] digi_q, digi_d;
    logic [31:0]       tick_q, tick_d;

    logic [2:0] sel;
    logic       wr_en;
    logic       overflow;
    logic       unused_addr_lsb;

    // Byte-lane bits are ignored: the window only supports word accesses.
    assign unused_addr_lsb = ^Address[1:0];

    assign hit      = (Address[31:5] == BASE_ADDR[31:5]);
    assign sel      = Address[4:2];
    assign wr_en    = MemWrite && hit;
    assign overflow = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

    assign irq  = tcon_q[2];
    assign leds = led_q;
    assign digi = digi_q;

    // Load data mux: pre-write register values, zero outside the window or without MemRead.
    always_comb begin
        Read_data = '0;
        if (MemRead && hit) begin
            case (sel)
                SEL_TH:   Read_data = th_q;
                SEL_TL:   Read_data = tl_q;
                SEL_TCON: Read_data[2:0] = tcon_q;
                SEL_LED:  Read_data[LED_W-1:0] = led_q;
                SEL_DIGI: Read_data[DIGI_W-1:0] = digi_q;
                SEL_TICK: Read_data = tick_q;
                default:  Read_data = '0;
            endcase
        end
    end

    // Next state: hardware timer behaviour first, then software writes layered on top.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        digi_d = digi_q;
        tick_d = tick_q + 32'd1;

        // Reload uses the TH value held before any same-cycle write to TH.
        if (tcon_q[0]) begin
            tl_d = overflow ? th_q : (tl_q + 32'd1);
        end

        if (wr_en) begin
            case (sel)
                SEL_TH:   th_d   = Write_data;
                SEL_TL:   tl_d   = Write_data;
                SEL_TCON: tcon_d = Write_data[2:0];
                SEL_LED:  led_d  = Write_data[LED_W-1:0];
                SEL_DIGI: digi_d = Write_data[DIGI_W-1:0];
                default:  ;
            endcase
        end

        // A flag-setting overflow beats a software clear so no interrupt is lost.
        if (overflow && tcon_q[1]) begin
            tcon_d[2] = 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            led_q  <= '0;
            digi_q <= '0;
            tick_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: tb/tb_periph_responder.sv
// Bench for periph_responder: directed scenarios then random traffic against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every access completes in one cycle, so the model advances exactly once per clock.
module tb_periph_responder;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Address, Write_data;
    logic [31:0] Read_data;
    logic        hit, irq;
    logic [7:0]  leds;
    logic [11:0] digi;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model of the register file.
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;

    logic [31:0] last_rd;
    logic        last_hit, last_irq;

    periph_responder #(.BASE_ADDR(BASE), .LED_W(8), .DIGI_W(12)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
        .hit(hit), .irq(irq), .leds(leds), .digi(digi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic in_win(input logic [31:0] a);
        return (a & 32'hFFFF_FFE0) == BASE;
    endfunction

    function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
        logic [31:0] off;
        if (!(rd && in_win(a))) return 32'h0;
        off = (a - BASE) / 4;
        case (off)
            0:       return m_th;
            1:       return m_tl;
            2:       return {29'h0, m_tcon};
            3:       return {24'h0, m_led};
            4:       return {20'h0, m_digi};
            5:       return m_tick;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_tick = 0;
    endtask

    // One clock of the register map, applied from the rules in plain arithmetic.
    task automatic model_step(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        logic        ov;
        logic [31:0] ntl, off;
        logic [2:0]  ntc;
        ov  = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
        ntl = m_tl;
        ntc = m_tcon;
        if (m_tcon[0]) ntl = ov ? m_th : m_tl + 1;
        if (wr && in_win(a)) begin
            off = (a - BASE) / 4;
            if (off == 0) m_th = wd;
            if (off == 1) ntl = wd;
            if (off == 2) ntc = wd[2:0];
            if (off == 3) m_led = wd[7:0];
            if (off == 4) m_digi = wd[11:0];
        end
        if (ov && m_tcon[1]) ntc[2] = 1'b1;
        m_tl   = ntl;
        m_tcon = ntc;
        m_tick = m_tick + 1;
    endtask

    // Drive one bus cycle, check all outputs against the model, advance one clock.
    task automatic do_cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        MemRead = rd; MemWrite = wr; Address = a; Write_data = wd;
        #4;
        last_rd  = Read_data;
        last_hit = hit;
        last_irq = irq;
        chk("rdata", Read_data, model_read(rd, a));
        chk("hit", {31'h0, hit}, {31'h0, in_win(a)});
        chk("irq", {31'h0, irq}, {31'h0, m_tcon[2]});
        chk("leds", {24'h0, leds}, {24'h0, m_led});
        chk("digi", {20'h0, digi}, {20'h0, m_digi});
        @(posedge clk);
        model_step(wr, a, wd);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] off, input logic [31:0] d);
        do_cycle(1'b0, 1'b1, BASE + {27'h0, off}, d);
    endtask

    task automatic rd_reg(input logic [4:0] off);
        do_cycle(1'b1, 1'b0, BASE + {27'h0, off}, 32'h0);
    endtask

    initial begin
        logic [31:0] ra;
        int          guard;
        reset = 1'b1; MemRead = 0; MemWrite = 0; Address = 0; Write_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_leds", {24'h0, leds}, 32'h0);
        chk("rst_digi", {20'h0, digi}, 32'h0);
        reset = 1'b0;

        // All offsets read zero after reset (SYSTICK first, before it advances).
        rd_reg(5'h14); chk("rst_rd_14", last_rd, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i != 5) begin
                rd_reg(5'(i * 4));
                chk("rst_rd_off", last_rd, 32'h0);
            end
        end

        // LED / DIGI registers.
        wr_reg(5'h0C, 32'hFFFF_FFA5);
        wr_reg(5'h10, 32'h0000_03F6);
        chk("leds_a5", {24'h0, leds}, 32'h0000_00A5);
        rd_reg(5'h10); chk("digi_rd", last_rd, 32'h0000_03F6);
        chk("digi_3f6", {20'h0, digi}, 32'h0000_03F6);
        do_cycle(1'b0, 1'b0, BASE + 32'h0C, 32'h0);
        chk("led_nord", last_rd, 32'h0);

        // Timer overflow and reload.
        wr_reg(5'h00, 32'hFFFF_FFF0);
        wr_reg(5'h04, 32'hFFFF_FFFD);
        wr_reg(5'h08, 32'h0000_0003);
        rd_reg(5'h04); chk("tl_fffd", last_rd, 32'hFFFF_FFFD);
        rd_reg(5'h04); chk("tl_fffe", last_rd, 32'hFFFF_FFFE);
        chk("irq_pre0", {31'h0, last_irq}, 32'h0);
        rd_reg(5'h04); chk("tl_ffff", last_rd, 32'hFFFF_FFFF);
        chk("irq_pre1", {31'h0, last_irq}, 32'h0);
        rd_reg(5'h04); chk("tl_reload", last_rd, 32'hFFFF_FFF0);
        chk("irq_set", {31'h0, last_irq}, 32'h1);

        // Software clear racing a flag-setting overflow loses; a later clear wins.
        guard = 0;
        while (m_tl != 32'hFFFF_FFFF && guard < 40) begin
            rd_reg(5'h04);
            guard++;
        end
        chk("reach_ovf", m_tl, 32'hFFFF_FFFF);
        wr_reg(5'h08, 32'h0000_0003);
        rd_reg(5'h08); chk("irq_kept", {31'h0, last_irq}, 32'h1);
        chk("tcon_kept", last_rd, 32'h0000_0007);
        wr_reg(5'h08, 32'h0000_0003);
        rd_reg(5'h08); chk("irq_clr", {31'h0, last_irq}, 32'h0);

        // TL write while counting; SYSTICK is read-only.
        wr_reg(5'h04, 32'h0000_1234);
        rd_reg(5'h04); chk("tl_1234", last_rd, 32'h0000_1234);
        rd_reg(5'h04); chk("tl_1235", last_rd, 32'h0000_1235);
        rd_reg(5'h14);
        wr_reg(5'h14, 32'h0000_0055);
        rd_reg(5'h14);
        rd_reg(5'h14);

        // Accesses outside the window.
        do_cycle(1'b1, 1'b1, 32'h4000_0020, 32'hDEAD_BEEF);
        chk("oow1_hit", {31'h0, last_hit}, 32'h0);
        chk("oow1_rd", last_rd, 32'h0);
        do_cycle(1'b1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
        chk("oow2_hit", {31'h0, last_hit}, 32'h0);
        chk("oow2_rd", last_rd, 32'h0);
        rd_reg(5'h00); chk("th_intact", last_rd, 32'hFFFF_FFF0);
        rd_reg(5'h0C); chk("led_intact", last_rd, 32'h0000_00A5);
        wr_reg(5'h18, 32'hFFFF_FFFF);
        rd_reg(5'h18); chk("unmapped", last_rd, 32'h0);

        // Random traffic, mostly inside the window.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) ra = BASE + $urandom_range(0, 31);
            else                          ra = $urandom;
            do_cycle(1'($urandom), 1'($urandom), ra, $urandom);
        end

        // Asynchronous reset while counting with the flag set.
        wr_reg(5'h00, 32'h0000_0100);
        wr_reg(5'h08, 32'h0000_0003);
        wr_reg(5'h04, 32'hFFFF_FFFE);
        rd_reg(5'h04);
        rd_reg(5'h04);
        chk("irq_before_rst", {31'h0, irq}, 32'h1);
        MemRead = 1'b1; MemWrite = 1'b0; Address = BASE + 32'h04;
        #2 reset = 1'b1;
        #1;
        chk("async_tl", Read_data, 32'h0);
        chk("async_irq", {31'h0, irq}, 32'h0);
        chk("async_leds", {24'h0, leds}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_reg(5'h04); chk("post_rst_tl0", last_rd, 32'h0);
        rd_reg(5'h04); chk("post_rst_tl1", last_rd, 32'h0);
        rd_reg(5'h08); chk("post_rst_tcon", last_rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout assertions=%0d failures=%0d", n_assert, n_fail);
        $fatal(1, "timeout");
    end

endmodule
